lut_mult_rr_sched: RTL
======================

Name: lut_mult_rr_sched

Overview:
- Round-robin scheduler that shares one signed 4x4 LUT-multiplier lane among NREQ requesters.
- Each requester supplies a 4-bit signed activation and a 4-bit signed weight code. The block grants one request per cycle, runs it through a 2-stage pipeline, and returns an 8-bit signed product tagged with the requester id.
- Sits between the activation fetch units and the shared constant-weight multiplier bank in the multipliers datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_act  in  4*NREQ  signed activations; requester i uses bits [4i+3:4i].
- req_wt  in  4*NREQ  signed weight codes, range -8..7; requester i uses bits [4i+3:4i].
- req_ready  out  NREQ  one-hot grant; request i is accepted when req_valid[i] and req_ready[i] are both high at a clock edge.
- resp_valid  out  1  product available.
- resp_ready  in  1  downstream accepts product.
- resp_prod  out  8  signed product act*wt, two's complement.
- resp_id  out  IDW  index of the requester that issued this product.
- busy  out  1  high while either pipeline stage holds valid data.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - s1_vld, s2_vld and rr_ptr clear to 0.
  - resp_valid=0, resp_prod=0, resp_id=0, busy=0.
  - req_ready is forced to 0 while rst_n=0.
  - In-flight transactions are dropped silently; a reset mid-stall loses the held product.
- Pipeline:
  - S1 registers {act, wt, id}.
  - S2 registers {product, id}; S2 drives resp_prod and resp_id.
  - resp_valid = s2_vld.
- Flow control:
  - s2_adv = !s2_vld | resp_ready.
  - s1_adv = !s1_vld | s2_adv.
  - accept_ok = s1_adv.
  - S2 loads from S1 when s2_adv; s2_vld <= s1_vld in that case.
  - S1 loads the granted request when s1_adv; s1_vld <= (any grant).
- Latency: a request accepted at edge k gives resp_valid=1 after edge k+1, and the response is consumed at edge k+2 if resp_ready=1. Sustained throughput is one product per cycle.
- Stall: while resp_valid=1 and resp_ready=0:
  - resp_prod and resp_id stay stable.
  - S1 holds if full.
  - req_ready stays 0 once S1 is full.
  - No data is lost or duplicated.
- Arbitration:
  - Search order is rr_ptr, rr_ptr+1, ... mod NREQ.
  - The first requester with req_valid=1 gets req_ready=1, only when accept_ok=1.
  - req_ready is combinational from req_valid, rr_ptr and pipeline state.
  - On each accepted grant to requester g, rr_ptr <= (g+1) mod NREQ. Otherwise rr_ptr holds.
  - Wrap-around: with g=NREQ-1, rr_ptr <= 0.
  - No requester waits more than NREQ-1 accepted grants while it holds req_valid.
- Product arithmetic:
  - resp_prod = sign-extended act times sign-extended wt, as full 8-bit signed.
  - Range is -56..+64; (-8)*(-8)=+64 fits in 8 bits, i.e. 8'h40.
  - wt=0 gives 0; no saturation is applied.
- Requester side: once req_valid[i] is raised, req_act and req_wt hold until acceptance; the block does not check this.
- busy = s1_vld | s2_vld.

Test Plan:
- Reset check: hold rst_n=0 two cycles with all req_valid=1 -> req_ready=0, resp_valid=0, busy=0. Release; first grant goes to req 0 (rr_ptr=0).
- Single request: req 2 with act=4'b1101 (-3) and wt=4'b0111 (+7), resp_ready=1 -> accepted at edge k; resp_valid=1 after edge k+1 with resp_prod=8'hEB (-21) and resp_id=2.
- Extremes: act=-8, wt=-8 -> 8'h40. act=7, wt=-8 -> 8'hC8. act=-8, wt=7 -> 8'hC8. wt=0 -> 8'h00.
- Round-robin fairness: all 4 req_valid held high for 8 accepts -> grant order 0,1,2,3,0,1,2,3. Then only req 1 and req 3 valid with rr_ptr=2 -> order 3,1,3,1.
- Backpressure: stream 3 requests, drop resp_ready for 3 cycles after the first response -> resp_prod/resp_id stable, S1 full, req_ready=0. Restore resp_ready -> remaining responses arrive in order with no loss or duplication.
- Reset mid-operation: rst_n=0 for one cycle with s1_vld=s2_vld=1 -> next cycle resp_valid=0, busy=0, rr_ptr=0, and no stale response emerges afterwards.

Source files
------------

// File: rtl/lut_mult_rr_sched.sv
// Round-robin arbiter feeding one shared signed 4x4 multiplier lane.
// Two-stage pipeline: P1 holds the granted operands, P2 holds the product and requester id.
module lut_mult_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [4*NREQ-1:0]      req_act,
    input  logic [4*NREQ-1:0]      req_wt,
    output logic [NREQ-1:0]        req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic signed [7:0]      resp_prod,
    output logic [IDW-1:0]         resp_id,
    output logic                   busy
);

    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                  vld_p1_q, vld_p1_d;
    logic signed [3:0]     act_p1_q, act_p1_d;
    logic signed [3:0]     wt_p1_q, wt_p1_d;
    logic [IDW-1:0]        id_p1_q, id_p1_d;
    logic                  vld_p2_q, vld_p2_d;
    logic signed [7:0]     prod_p2_q, prod_p2_d;
    logic [IDW-1:0]        id_p2_q, id_p2_d;

    logic                  s1_adv, s2_adv, accept_ok;
    logic                  found, accept;
    logic [IDW-1:0]        gnt_id;
    logic [IDW:0]          cand;

    // Full signed product; (-8)*(-8)=+64 still fits in 8 bits, so no saturation is needed.
    function automatic logic signed [7:0] lut_mult(input logic signed [3:0] a,
                                                   input logic signed [3:0] w);
        logic signed [7:0] a_ext;
        logic signed [7:0] w_ext;
        a_ext = {{4{a[3]}}, a};
        w_ext = {{4{w[3]}}, w};
        return a_ext * w_ext;
    endfunction

    assign s2_adv    = !vld_p2_q || resp_ready;
    assign s1_adv    = !vld_p1_q || s2_adv;
    assign accept_ok = s1_adv;

    // Search from rr_ptr upward, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        found     = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                gnt_id = cand[IDW-1:0];
            end
        end
        accept = found && accept_ok && rst_n;
        if (accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        vld_p1_d  = vld_p1_q;
        act_p1_d  = act_p1_q;
        wt_p1_d   = wt_p1_q;
        id_p1_d   = id_p1_q;
        vld_p2_d  = vld_p2_q;
        prod_p2_d = prod_p2_q;
        id_p2_d   = id_p2_q;

        if (accept) begin
            rr_ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
        end

        // Stage P1: capture granted operands
        if (s1_adv) begin
            vld_p1_d = accept;
            act_p1_d = req_act[{gnt_id, 2'b00} +: 4];
            wt_p1_d  = req_wt[{gnt_id, 2'b00} +: 4];
            id_p1_d  = gnt_id;
        end

        // Stage P2: multiply and present to downstream
        if (s2_adv) begin
            vld_p2_d  = vld_p1_q;
            prod_p2_d = lut_mult(act_p1_q, wt_p1_q);
            id_p2_d   = id_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            vld_p1_q  <= 1'b0;
            act_p1_q  <= '0;
            wt_p1_q   <= '0;
            id_p1_q   <= '0;
            vld_p2_q  <= 1'b0;
            prod_p2_q <= '0;
            id_p2_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            vld_p1_q  <= vld_p1_d;
            act_p1_q  <= act_p1_d;
            wt_p1_q   <= wt_p1_d;
            id_p1_q   <= id_p1_d;
            vld_p2_q  <= vld_p2_d;
            prod_p2_q <= prod_p2_d;
            id_p2_q   <= id_p2_d;
        end
    end

    assign resp_valid = vld_p2_q;
    assign resp_prod  = prod_p2_q;
    assign resp_id    = id_p2_q;
    assign busy       = vld_p1_q | vld_p2_q;

endmodule
